spi_xfer_arbiter: RTL

Transaction controller that shares one SPI clock generator and one MOSI/MISO pair among NREQ requesters. It arbitrates pending requests round-robin, drives the selected chip select, and starts the clock generator with the bit count. It shifts MOSI out and MISO in using the generator's edge strobes, then returns the received word with a one-cycle done pulse. The block sits between the register/host interfaces and the clock generator, which it owns exclusively.

---
 rtl/spi_xfer_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_arbiter.sv
// Round-robin SPI transaction controller: grants one of NREQ requesters, drives its chip
// select, runs the shared clock generator and shifts MOSI/MISO on the generator's edge strobes.
module spi_xfer_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 16,
    parameter int Nc    = 6,
    parameter int TCSH  = 2,
    parameter int TIDLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*Nc-1:0]   req_len,
    input  logic [NREQ*W-1:0]    req_tx,
    output logic [NREQ-1:0]      done,
    output logic [W-1:0]         rx_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [NREQ-1:0]      cs_n,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 gen_start,
    output logic [Nc-1:0]        gen_clk_count,
    input  logic                 gen_busy,
    input  logic                 gen_pos_edge,
    input  logic                 gen_neg_edge
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, GAP} state_t;

    // TCSH=0 still keeps CS low for one cycle after the generator stops
    localparam logic [3:0] HOLD_LAST = (TCSH == 0) ? 4'd0 : 4'(TCSH - 1);
    localparam logic [3:0] GAP_LAST  = 4'(TIDLE - 1);
    localparam logic [Nc-1:0] MAX_LEN = Nc'(W - 1);

    state_t state_reg, state_next;

    logic [2:0]      ptr_reg;
    logic [2:0]      grant_id_reg;
    logic [NREQ-1:0] cs_n_reg;
    logic [NREQ-1:0] done_reg;
    logic [W-1:0]    tx_sr_reg;
    logic [W-1:0]    rx_sr_reg;
    logic [W-1:0]    rx_data_reg;
    logic            mosi_reg;
    logic            gen_start_reg;
    logic [Nc-1:0]   gen_clk_count_reg;
    logic            busy_reg;
    logic [3:0]      cnt_reg;

    logic [Nc-1:0]   len_arr [8];
    logic [W-1:0]    tx_arr  [8];
    logic [7:0]      req_pad;

    logic            pick_valid;
    logic [2:0]      pick_id;
    logic [2:0]      cand;
    logic [Nc-1:0]   pick_len;
    logic [W-1:0]    pick_tx_al;
    logic            grant_now;
    logic            hold_exit;
    logic            gap_exit;

    // Unpack the flat request buses into 8-entry tables so a 3-bit id indexes them exactly
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fields
            if (gi < NREQ) begin : g_used
                assign len_arr[gi] = req_len[gi*Nc +: Nc];
                assign tx_arr[gi]  = req_tx[gi*W +: W];
                assign req_pad[gi] = req[gi];
            end else begin : g_unused
                assign len_arr[gi] = '0;
                assign tx_arr[gi]  = '0;
                assign req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Walk from farthest to nearest candidate so the one right after the pointer wins
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_reg) + k >= NREQ) ? 3'(int'(ptr_reg) + k - NREQ)
                                               : 3'(int'(ptr_reg) + k);
            if (req_pad[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Left-align the transmit word so bit L sits in the MSB of the shift register
    always_comb begin
        pick_len = len_arr[pick_id];
        if (pick_len > MAX_LEN) begin
            pick_len = MAX_LEN;
        end
        pick_tx_al = tx_arr[pick_id] << (MAX_LEN - pick_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Arbitration also runs in the last GAP cycle so back-to-back transfers see only TIDLE
    always_comb begin
        state_next = state_reg;
        grant_now  = 1'b0;
        hold_exit  = 1'b0;
        gap_exit   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_now  = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (gen_busy) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!gen_busy) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    hold_exit  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    gap_exit = 1'b1;
                    if (pick_valid) begin
                        grant_now  = 1'b1;
                        state_next = ARM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg           <= 3'(NREQ - 1);
            grant_id_reg      <= '0;
            cs_n_reg          <= '1;
            done_reg          <= '0;
            tx_sr_reg         <= '0;
            rx_sr_reg         <= '0;
            rx_data_reg       <= '0;
            mosi_reg          <= 1'b0;
            gen_start_reg     <= 1'b0;
            gen_clk_count_reg <= '0;
            busy_reg          <= 1'b0;
            cnt_reg           <= '0;
        end else begin
            gen_start_reg <= 1'b0;
            done_reg      <= '0;
            cnt_reg       <= (state_next != state_reg) ? 4'd0 : cnt_reg + 4'd1;

            if (grant_now) begin
                ptr_reg           <= pick_id;
                grant_id_reg      <= pick_id;
                cs_n_reg          <= ~(NREQ'(1) << pick_id);
                tx_sr_reg         <= pick_tx_al;
                mosi_reg          <= pick_tx_al[W-1];
                rx_sr_reg         <= '0;
                gen_start_reg     <= 1'b1;
                gen_clk_count_reg <= pick_len;
                busy_reg          <= 1'b1;
            end else if (gap_exit) begin
                busy_reg <= 1'b0;
            end

            if (state_reg == ARM || state_reg == RUN) begin
                if (gen_pos_edge) begin
                    rx_sr_reg <= {rx_sr_reg[W-2:0], miso};
                end
                if (gen_neg_edge) begin
                    tx_sr_reg <= tx_sr_reg << 1;
                    mosi_reg  <= tx_sr_reg[W-2];
                end
            end

            if (hold_exit) begin
                cs_n_reg    <= '1;
                done_reg    <= NREQ'(1) << grant_id_reg;
                rx_data_reg <= rx_sr_reg;
                mosi_reg    <= 1'b0;
            end
        end
    end

    assign done          = done_reg;
    assign rx_data       = rx_data_reg;
    assign grant_id      = grant_id_reg;
    assign busy          = busy_reg;
    assign cs_n          = cs_n_reg;
    assign mosi          = mosi_reg;
    assign gen_start     = gen_start_reg;
    assign gen_clk_count = gen_clk_count_reg;

endmodule
